lwe_decrypt: RTL and testbench

//  Streaming LWE decryption stage that sits directly downstream of homomorphic_add and consumes its ciphertext results.
//  - Ciphertext = DIMENSION mask words a[i] plus body word b.
//  - Accumulates <a,s> over ceil(DIMENSION/PARALLEL) beats with a streamed secret key.
//  - Recovers the plaintext: m = round((b - <a,s>) * P / Q) mod P.
//  - Valid/ready on both sides; one ciphertext in flight.

---
 rtl/lwe_decrypt.sv | 148 ++++++++++++++
 tb/tb_lwe_decrypt.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lwe_decrypt.sv
// Streaming LWE decryption: accumulates <a,s> over several beats, then rounds (b - <a,s>) down to a plaintext.
// Optional LWE_NOISE_CHECK_EN adds noise_flag, raised when the rounding residual is at least DELTA/4.
module lwe_decrypt #(
   parameter int PLAINTEXT_MODULUS  = 64,
   parameter int PLAINTEXT_WIDTH    = 6,
   parameter int CIPHERTEXT_MODULUS = 1024,
   parameter int CIPHERTEXT_WIDTH   = 10,
   parameter int DIMENSION          = 4,
   parameter int PARALLEL           = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] ct_a,
   input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] sk,
   input  logic [CIPHERTEXT_WIDTH-1:0]          ct_b,
   output logic                                 pt_valid,
   input  logic                                 pt_ready,
`ifdef LWE_NOISE_CHECK_EN
   output logic [PLAINTEXT_WIDTH-1:0]           pt,
   output logic                                 noise_flag
`else
   output logic [PLAINTEXT_WIDTH-1:0]           pt
`endif
);

   localparam int CW    = CIPHERTEXT_WIDTH;
   localparam int PW    = PLAINTEXT_WIDTH;
   localparam int DW    = CW - PW;
   localparam int DELTA = CIPHERTEXT_MODULUS / PLAINTEXT_MODULUS;
   localparam int BEATS = (DIMENSION + PARALLEL - 1) / PARALLEL;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {ACCUM, DECODE, OUT} state_t;

   state_t          state;
   state_t          next_state;
   logic [BW-1:0]   beat;
   logic [CW-1:0]   acc;
   logic [CW-1:0]   b_reg;
   logic [CW-1:0]   lane_sum;
   logic [CW-1:0]   diff;
   logic [CW-1:0]   round_sum;
   logic [PW-1:0]   pt_next;
   logic            last_beat;
   logic            accept;

   assign last_beat = (beat == BW'(BEATS - 1));
   assign accept    = (state == ACCUM) && in_valid;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state <= ACCUM;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      pt_valid   = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && last_beat) begin
               next_state = DECODE;
            end
         end
         DECODE: begin
            next_state = OUT;
         end
         OUT: begin
            pt_valid = 1'b1;
            if (pt_ready) begin
               next_state = ACCUM;
            end
         end
         default: begin
            next_state = ACCUM;
         end
      endcase
   end

   // Lanes past the end of the mask vector (only possible on the last beat) contribute nothing.
   always_comb begin
      lane_sum = '0;
      for (int k = 0; k < PARALLEL; k++) begin
         if ((int'(beat) * PARALLEL + k) < DIMENSION) begin
            lane_sum = lane_sum + ct_a[k*CW +: CW] * sk[k*CW +: CW];
         end
      end
   end

   // Adding DELTA/2 in CW bits lets a diff just below Q wrap to 0, which is the mod-P reduction of P.
   always_comb begin
      diff      = b_reg - acc;
      round_sum = diff + CW'(DELTA / 2);
      pt_next   = PW'(round_sum >> DW);
   end

`ifdef LWE_NOISE_CHECK_EN
   logic [CW-1:0] residual;
   logic [CW-1:0] residual_mag;
   logic          noise_next;

   always_comb begin
      residual     = diff - {pt_next, {DW{1'b0}}};
      residual_mag = residual[CW-1] ? (~residual + 1'b1) : residual;
      noise_next   = (residual_mag >= CW'(DELTA / 4));
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         noise_flag <= 1'b0;
      end else if (state == DECODE) begin
         noise_flag <= noise_next;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst_n) begin
         acc   <= '0;
         beat  <= '0;
         b_reg <= '0;
         pt    <= '0;
      end else begin
         if (accept) begin
            acc <= acc + lane_sum;
            if (last_beat) begin
               b_reg <= ct_b;
            end else begin
               beat <= beat + 1'b1;
            end
         end
         if (state == DECODE) begin
            pt <= pt_next;
         end
         if ((state == OUT) && pt_ready) begin
            acc  <= '0;
            beat <= '0;
         end
      end
   end

endmodule

// File: tb/tb_lwe_decrypt.sv
// Randomised and directed bench for lwe_decrypt against an integer-arithmetic model of LWE decryption.
module tb_lwe_decrypt;

   localparam int P     = 64;
   localparam int PW    = 6;
   localparam int Q     = 1024;
   localparam int CW    = 10;
   localparam int DIM   = 4;
   localparam int PAR   = 2;
   localparam int DELTA = Q / P;
   localparam int BEATS = (DIM + PAR - 1) / PAR;

   logic                clk = 1'b0;
   logic                rst_n = 1'b1;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [PAR*CW-1:0]   ct_a = '0;
   logic [PAR*CW-1:0]   sk = '0;
   logic [CW-1:0]       ct_b = '0;
   logic                pt_valid;
   logic                pt_ready = 1'b0;
   logic [PW-1:0]       pt;
`ifdef LWE_NOISE_CHECK_EN
   logic                noise_flag;
`endif

   int check_count = 0;
   int error_count = 0;

   int cur_a [DIM];
   int cur_s [DIM];
   int cur_b;
   int exp_pt;
   int exp_flag;

   lwe_decrypt #(
      .PLAINTEXT_MODULUS(P), .PLAINTEXT_WIDTH(PW), .CIPHERTEXT_MODULUS(Q),
      .CIPHERTEXT_WIDTH(CW), .DIMENSION(DIM), .PARALLEL(PAR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ct_a(ct_a), .sk(sk), .ct_b(ct_b), .pt_valid(pt_valid), .pt_ready(pt_ready),
`ifdef LWE_NOISE_CHECK_EN
      .pt(pt), .noise_flag(noise_flag)
`else
      .pt(pt)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int got, input int want);
      check_count++;
      if (got != want) begin
         error_count++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference decryption in plain integer arithmetic.
   task automatic computeExpected();
      int dot, diff, res;
      dot = 0;
      for (int i = 0; i < DIM; i++) dot = (dot + cur_a[i] * cur_s[i]) % Q;
      diff   = ((cur_b - dot) % Q + Q) % Q;
      exp_pt = ((diff + DELTA / 2) / DELTA) % P;
      res    = ((diff - exp_pt * DELTA) % Q + Q) % Q;
      if (res >= Q / 2) res = res - Q;
      if (res < 0) res = -res;
      exp_flag = (res >= DELTA / 4) ? 1 : 0;
   endtask

   task automatic driveBeat(input int bt);
      for (int k = 0; k < PAR; k++) begin
         int idx;
         idx = bt * PAR + k;
         ct_a[k*CW +: CW] = (idx < DIM) ? CW'(cur_a[idx]) : CW'($urandom);
         sk[k*CW +: CW]   = (idx < DIM) ? CW'(cur_s[idx]) : CW'($urandom);
      end
      ct_b = (bt == BEATS - 1) ? CW'(cur_b) : CW'($urandom);
      in_valid = 1'b1;
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
      checkOutput({tag, "_pt_valid"}, int'(pt_valid), 0);
      checkOutput({tag, "_pt"}, int'(pt), 0);
`ifdef LWE_NOISE_CHECK_EN
      checkOutput({tag, "_noise"}, int'(noise_flag), 0);
`endif
   endtask

   task automatic applyReset();
      rst_n = 1'b1;
      in_valid = 1'b0;
      pt_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
   endtask

   // Sends one ciphertext, then holds pt_ready low for 'stall' cycles while upstream keeps offering junk.
   task automatic applyStimulus(input string tag, input int stall);
      int waited;
      computeExpected();
      for (int bt = 0; bt < BEATS; bt++) begin
         driveBeat(bt);
         waited = 0;
         while (!in_ready && waited < 10) begin
            tick();
            waited++;
         end
         if (!in_ready) checkOutput({tag, "_ready_timeout"}, 0, 1);
         tick();
      end
      for (int k = 0; k < PAR; k++) begin
         ct_a[k*CW +: CW] = CW'($urandom);
         sk[k*CW +: CW]   = CW'($urandom);
      end
      ct_b = CW'($urandom);
      checkOutput({tag, "_decode_in_ready"}, int'(in_ready), 0);
      checkOutput({tag, "_decode_pt_valid"}, int'(pt_valid), 0);
      waited = 0;
      while (!pt_valid && waited < 8) begin
         tick();
         waited++;
      end
      checkOutput({tag, "_pt_valid"}, int'(pt_valid), 1);
      checkOutput({tag, "_pt"}, int'(pt), exp_pt);
`ifdef LWE_NOISE_CHECK_EN
      checkOutput({tag, "_noise"}, int'(noise_flag), exp_flag);
`endif
      for (int c = 0; c < stall; c++) begin
         tick();
         checkOutput({tag, "_hold_valid"}, int'(pt_valid), 1);
         checkOutput({tag, "_hold_pt"}, int'(pt), exp_pt);
         checkOutput({tag, "_hold_in_ready"}, int'(in_ready), 0);
      end
      pt_ready = 1'b1;
      tick();
      pt_ready = 1'b0;
      in_valid = 1'b0;
      checkOutput({tag, "_release_in_ready"}, int'(in_ready), 1);
      checkOutput({tag, "_release_pt_valid"}, int'(pt_valid), 0);
   endtask

   task automatic setCase2(input int b);
      for (int i = 0; i < DIM; i++) begin
         cur_a[i] = i + 1;
         cur_s[i] = 1;
      end
      cur_b = b;
   endtask

   initial begin
      applyReset();
      tick();
      checkReset("reset");

      for (int i = 0; i < DIM; i++) begin
         cur_a[i] = $urandom_range(0, Q - 1);
         cur_s[i] = 0;
      end
      cur_b = 48;
      applyStimulus("zero_key", 0);
      checkOutput("zero_key_model", exp_pt, 3);

      setCase2(93);
      applyStimulus("basic", 0);
      setCase2(2);
      applyStimulus("wrap", 0);
      setCase2(96);
      applyStimulus("noise", 0);
      setCase2(93);
      applyStimulus("backpressure", 3);

      // Abort a ciphertext after its first beat; nothing of it may leak into the next one.
      for (int i = 0; i < DIM; i++) begin
         cur_a[i] = $urandom_range(1, Q - 1);
         cur_s[i] = $urandom_range(1, Q - 1);
      end
      cur_b = $urandom_range(0, Q - 1);
      driveBeat(0);
      tick();
      in_valid = 1'b0;
      applyReset();
      checkReset("mid_reset");
      setCase2(93);
      applyStimulus("after_reset", 0);

      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < DIM; i++) begin
            cur_a[i] = $urandom_range(0, Q - 1);
            cur_s[i] = $urandom_range(0, Q - 1);
         end
         cur_b = $urandom_range(0, Q - 1);
         applyStimulus("random", $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
